alu_mc: RTL and testbench
=========================

# alu_mc

Multi-cycle, parametrised execute-stage ALU that replaces the single-cycle combinational ALU. It keeps the existing logic, shift, compare and test operations and adds iterative unsigned multiply, divide and modulo. Results and flags are registered behind a valid/ready handshake, so the pipeline can stall on long operations. It sits between the ID/EX register and the EX/MEM register and drives the branch unit from its registered flags.

## Interface
- DATA_WIDTH, 32: operand and result width; must be a power of two, at least 8.
- SIGNED_CMP, 0: 1 means `less`/`greater` use a signed compare; 0 means unsigned.
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand/op valid
- in_ready  out  1  block accepts an op this cycle
- alu_op  in  ALU_OP_BITS (5)  operation code from alu_defs
- data1, data2  in  DATA_WIDTH  operands
- out_valid  out  1  result register valid
- out_ready  in  1  consumer accepts the result
- alu_result  out  DATA_WIDTH  registered result
- compare  out  1  data1 == data2 of the last accepted op
- zero, less, greater  out  1  sticky flags, updated only by CMP/TEST
- div_zero  out  1  last DIV/MOD had data2 == 0
- busy  out  1  multi-cycle operation in progress

## Operation
- Ops: ADD, SUB, NOT, AND, OR, NAND, NOR, XOR, MOV (data1), LI (data2), SHL, SHR, SAR, CMP, TEST, MUL, DIV, MOD.
- Shift amount is data2[$clog2(DATA_WIDTH)-1:0]. SAR is arithmetic, sign-filled from data1 MSB.
- MUL returns the low DATA_WIDTH bits of the unsigned product. DIV/MOD are unsigned.
- Divide by zero: DIV returns all-ones, MOD returns data1, and div_zero=1. div_zero is cleared by any other DIV/MOD.
- CMP: zero=(data1-data2)==0, less=data1<data2, greater=data1>data2.
- TEST: zero=(data1&data2)==0; less and greater are computed as in CMP.
- For CMP and TEST, alu_result=data1-data2 and data1&data2 respectively.
- Undefined op codes produce result 0 and leave the flags unchanged.
- States:
  - IDLE: wait for an accepted op.
  - MUL: one shift-add step per cycle.
  - DIV: one restoring-division step per cycle.
  - Transitions: IDLE goes to MUL or DIV on accept of a MUL or DIV/MOD op. MUL/DIV return to IDLE when the step counter reaches 0 and the result is written to the output register.
- Handshake:
  - Accept when in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Operands are latched on accept; later changes to the inputs are ignored.
  - out_valid holds, with alu_result and flags stable, until out_ready.
- Reset values: all outputs are 0, except in_ready=1 once reset is deasserted. State returns to IDLE.

## Timing
- Single-cycle ops:
  - Accepted in cycle N; out_valid=1 in cycle N+1.
  - Back-to-back throughput is 1 op/cycle when out_ready is held high.
- MUL/DIV/MOD:
  - Accepted in cycle N; busy=1 for cycles N+1..N+DATA_WIDTH.
  - out_valid=1 at N+DATA_WIDTH+1.
  - in_ready=0 throughout.
- Divide by zero still takes the full DATA_WIDTH+1 latency, so latency is data-independent.
- compare, zero, less, greater and div_zero update in the same cycle that out_valid rises for the producing op.
- If out_ready=0 when a multi-cycle op finishes, the result is held and in_ready stays 0 until the result drains.
- Reset asserted mid-operation aborts the op:
  - The next cycle shows the reset values.
  - No out_valid is produced for the aborted op.

## Structure
- Shared package alu_defs holds ALU_OP_BITS, all ALU_OP_* codes (existing codes unchanged; MUL/DIV/MOD appended) and the state encoding.
- One sub-module, alu_muldiv, holds the iterative shift-add/restoring divider and its step counter. Its handshake is start/done.
- alu_mc holds the single-cycle datapath, the output register, flag registers and the FSM.

## Test plan
- ADD 0xFFFFFFFF + 1 with out_ready=1 → alu_result=0 one cycle after accept; compare=0; zero/less/greater unchanged.
- SAR data1=0x80000000, data2=4 → 0xF8000000. SHR with the same operands → 0x08000000. Shift data2=36 → treated as 4.
- CMP 3,7 with SIGNED_CMP=0 → zero=0, less=1, greater=0. Then ADD 1,1 → flags still 0/1/0. CMP 0xFFFFFFFF,1 with SIGNED_CMP=1 → less=1.
- Multi-cycle ops:
  - MUL 12345×678 → 8369910 at accept+33 cycles, with in_ready=0 and busy=1 meanwhile.
  - DIV 100/7 → 14; MOD 100/7 → 2.
  - DIV 5/0 → 0xFFFFFFFF with div_zero=1.
- Backpressure: hold out_ready=0 after a result; in_valid stays asserted → in_ready=0 and the result stays stable. Release out_ready → the next op is accepted that cycle.
- Reset at cycle 10 of a DIV → next cycle out_valid=0, busy=0, flags=0, in_ready=1; no stale result appears.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// Shared ALU definitions: op codes, FSM state encoding and the flag payload.
package alu_defs;

  localparam int unsigned ALU_OP_BITS = 5;

  localparam logic [ALU_OP_BITS-1:0] ALU_OP_ADD  = 5'd0;
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_SUB  = 5'd1;
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_NOT  = 5'd2;
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_AND  = 5'd3;
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_OR   = 5'd4;
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_NAND = 5'd5;
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_NOR  = 5'd6;
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_XOR  = 5'd7;
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_MOV  = 5'd8;
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_LI   = 5'd9;
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_SHL  = 5'd10;
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_SHR  = 5'd11;
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_SAR  = 5'd12;
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_CMP  = 5'd13;
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_TEST = 5'd14;
  // Multi-cycle ops appended after the original single-cycle codes.
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_MUL  = 5'd15;
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_DIV  = 5'd16;
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_MOD  = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } alu_state_t;

  typedef struct packed {
    logic zero;
    logic less;
    logic greater;
  } alu_flags_t;

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned shift-add multiplier and restoring divider, one step per cycle.
module alu_muldiv #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done_c,
  output logic [DATA_WIDTH-1:0] prod_c,
  output logic [DATA_WIDTH-1:0] quo_c,
  output logic [DATA_WIDTH-1:0] rem_c
);

  localparam int unsigned CW = $clog2(DATA_WIDTH) + 1;

  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] mcand, mplier, acc;
  logic [DATA_WIDTH-1:0] quo, rem, dvsr;
  logic [DATA_WIDTH:0]   rem_sh;
  logic                  ge;

  // Next step values; on the last step these are the final results.
  // A zero divisor naturally yields quotient all-ones and remainder = dividend.
  always_comb begin
    prod_c = acc + (mplier[0] ? mcand : '0);
    rem_sh = {rem, quo[DATA_WIDTH-1]};
    ge     = rem_sh >= {1'b0, dvsr};
    quo_c  = {quo[DATA_WIDTH-2:0], ge};
    rem_c  = DATA_WIDTH'(ge ? (rem_sh - {1'b0, dvsr}) : rem_sh);
    done_c = (cnt == CW'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      quo    <= '0;
      rem    <= '0;
      dvsr   <= '0;
    end else if (start) begin
      cnt    <= CW'(DATA_WIDTH);
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      quo    <= a;
      rem    <= '0;
      dvsr   <= b;
    end else if (cnt != '0) begin
      cnt    <= cnt - CW'(1);
      acc    <= prod_c;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      quo    <= quo_c;
      rem    <= rem_c;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute ALU: single-cycle datapath, iterative mul/div, registered
// result and flags behind a valid/ready handshake.
module alu_mc
  import alu_defs::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          SIGNED_CMP = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ALU_OP_BITS-1:0] alu_op,
  input  logic [DATA_WIDTH-1:0]  data1,
  input  logic [DATA_WIDTH-1:0]  data2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  alu_result,
  output logic                   compare,
  output logic                   zero,
  output logic                   less,
  output logic                   greater,
  output logic                   div_zero,
  output logic                   busy
);

  localparam int unsigned SHW = $clog2(DATA_WIDTH);

  alu_state_t            state, state_n;
  alu_flags_t            flags, flags_n;
  logic                  accept, is_mul, is_div;
  logic [DATA_WIDTH-1:0] diff, andv, sc_result, result_n;
  logic [DATA_WIDTH-1:0] prod_c, quo_c, rem_c;
  logic [SHW-1:0]        shamt;
  logic                  eq, lt, gt, sc_upd, sc_zero, md_done_c;
  logic                  out_valid_n, busy_n, compare_n, div_zero_n;
  logic                  pend_mod, pend_mod_n, pend_eq, pend_eq_n, pend_dz, pend_dz_n;

  assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (alu_op == ALU_OP_MUL);
  assign is_div   = (alu_op == ALU_OP_DIV) || (alu_op == ALU_OP_MOD);
  assign zero     = flags.zero;
  assign less     = flags.less;
  assign greater  = flags.greater;

  alu_muldiv #(.DATA_WIDTH(DATA_WIDTH)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (accept && (is_mul || is_div)),
    .a      (data1),
    .b      (data2),
    .done_c (md_done_c),
    .prod_c (prod_c),
    .quo_c  (quo_c),
    .rem_c  (rem_c)
  );

  // Single-cycle datapath and compare logic.
  always_comb begin
    diff      = data1 - data2;
    andv      = data1 & data2;
    shamt     = data2[SHW-1:0];
    eq        = (data1 == data2);
    sc_result = '0;
    sc_upd    = 1'b0;
    sc_zero   = 1'b0;
    if (SIGNED_CMP) begin
      lt = $signed(data1) < $signed(data2);
      gt = $signed(data1) > $signed(data2);
    end else begin
      lt = data1 < data2;
      gt = data1 > data2;
    end
    case (alu_op)
      ALU_OP_ADD:  sc_result = data1 + data2;
      ALU_OP_SUB:  sc_result = diff;
      ALU_OP_NOT:  sc_result = ~data1;
      ALU_OP_AND:  sc_result = andv;
      ALU_OP_OR:   sc_result = data1 | data2;
      ALU_OP_NAND: sc_result = ~andv;
      ALU_OP_NOR:  sc_result = ~(data1 | data2);
      ALU_OP_XOR:  sc_result = data1 ^ data2;
      ALU_OP_MOV:  sc_result = data1;
      ALU_OP_LI:   sc_result = data2;
      ALU_OP_SHL:  sc_result = data1 << shamt;
      ALU_OP_SHR:  sc_result = data1 >> shamt;
      ALU_OP_SAR:  sc_result = DATA_WIDTH'($signed(data1) >>> shamt);
      ALU_OP_CMP: begin
        sc_result = diff;
        sc_upd    = 1'b1;
        sc_zero   = (diff == '0);
      end
      ALU_OP_TEST: begin
        sc_result = andv;
        sc_upd    = 1'b1;
        sc_zero   = (andv == '0);
      end
      default: sc_result = '0;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_n     = state;
    busy_n      = busy;
    out_valid_n = out_valid;
    result_n    = alu_result;
    compare_n   = compare;
    flags_n     = flags;
    div_zero_n  = div_zero;
    pend_mod_n  = pend_mod;
    pend_eq_n   = pend_eq;
    pend_dz_n   = pend_dz;
    if (out_valid && out_ready) out_valid_n = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          pend_eq_n = eq;
          if (is_mul) begin
            state_n = ST_MUL;
            busy_n  = 1'b1;
          end else if (is_div) begin
            state_n    = ST_DIV;
            busy_n     = 1'b1;
            pend_mod_n = (alu_op == ALU_OP_MOD);
            pend_dz_n  = (data2 == '0);
          end else begin
            out_valid_n = 1'b1;
            result_n    = sc_result;
            compare_n   = eq;
            if (sc_upd) begin
              flags_n.zero    = sc_zero;
              flags_n.less    = lt;
              flags_n.greater = gt;
            end
          end
        end
      end
      ST_MUL: begin
        if (md_done_c) begin
          state_n     = ST_IDLE;
          busy_n      = 1'b0;
          out_valid_n = 1'b1;
          result_n    = prod_c;
          compare_n   = pend_eq;
        end
      end
      ST_DIV: begin
        if (md_done_c) begin
          state_n     = ST_IDLE;
          busy_n      = 1'b0;
          out_valid_n = 1'b1;
          result_n    = pend_mod ? rem_c : quo_c;
          compare_n   = pend_eq;
          div_zero_n  = pend_dz;
        end
      end
      default: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      alu_result <= '0;
      compare    <= 1'b0;
      flags      <= '0;
      div_zero   <= 1'b0;
      pend_mod   <= 1'b0;
      pend_eq    <= 1'b0;
      pend_dz    <= 1'b0;
    end else begin
      state      <= state_n;
      busy       <= busy_n;
      out_valid  <= out_valid_n;
      alu_result <= result_n;
      compare    <= compare_n;
      flags      <= flags_n;
      div_zero   <= div_zero_n;
      pend_mod   <= pend_mod_n;
      pend_eq    <= pend_eq_n;
      pend_dz    <= pend_dz_n;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: arithmetic reference model with an expected-result
// queue, checked every cycle, plus hand-computed literals on directed vectors.
module tb_alu_mc;
  import alu_defs::*;

  localparam int unsigned W  = 32;
  localparam int unsigned SW = 5;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   out_ready = 1'b1;
  logic [ALU_OP_BITS-1:0] alu_op = '0;
  logic [W-1:0]           data1 = '0, data2 = '0;

  logic         in_ready, out_valid, compare, zero, less, greater, div_zero, busy;
  logic [W-1:0] alu_result;
  logic         s_in_ready, s_out_valid, s_compare, s_zero, s_less, s_greater, s_div_zero, s_busy;
  logic [W-1:0] s_alu_result;

  alu_mc #(.DATA_WIDTH(W), .SIGNED_CMP(1'b0)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op),
    .data1(data1), .data2(data2), .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .compare(compare), .zero(zero), .less(less),
    .greater(greater), .div_zero(div_zero), .busy(busy)
  );

  alu_mc #(.DATA_WIDTH(W), .SIGNED_CMP(1'b1)) u_dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready), .alu_op(alu_op),
    .data1(data1), .data2(data2), .out_valid(s_out_valid), .out_ready(out_ready),
    .alu_result(s_alu_result), .compare(s_compare), .zero(s_zero), .less(s_less),
    .greater(s_greater), .div_zero(s_div_zero), .busy(s_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         cmp;
    logic [2:0]   fl;
    logic [2:0]   sfl;
    logic         dz;
    int           due;
    logic         lit_use;
    logic [W-1:0] lit_res;
    logic         lit_fl_use;
    logic [3:0]   lit_fl;
    logic [2:0]   lit_sfl;
  } entry_t;

  entry_t       q[$];
  entry_t       ne;
  int           total = 0, bad = 0, cyc = 0, busy_end = 0;
  bit           started = 0;
  logic [2:0]   m_fl = '0, m_sfl = '0, sh_fl = '0, sh_sfl = '0;
  logic         m_dz = 1'b0, sh_dz = 1'b0, sh_cmp = 1'b0;
  logic [W-1:0] sh_res = '0, ma, mb;
  logic [63:0]  prod;
  logic [SW-1:0] sa;
  logic         lit_use = 1'b0, lit_fl_use = 1'b0;
  logic [W-1:0] lit_res = '0;
  logic [3:0]   lit_fl = '0;
  logic [2:0]   lit_sfl = '0;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %b want %b", name, cyc, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: evaluates each accepted op from its arithmetic definition.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      started = 1;
      q.delete();
      m_fl = '0; m_sfl = '0; m_dz = 1'b0;
      sh_fl = '0; sh_sfl = '0; sh_dz = 1'b0; sh_cmp = 1'b0; sh_res = '0;
      busy_end = 0;
    end else if (in_valid && in_ready) begin
      ma = data1;
      mb = data2;
      sa = mb[SW-1:0];
      ne.cmp = (ma == mb);
      ne.due = cyc;
      case (alu_op)
        ALU_OP_ADD:  ne.res = ma + mb;
        ALU_OP_SUB:  ne.res = ma - mb;
        ALU_OP_NOT:  ne.res = ~ma;
        ALU_OP_AND:  ne.res = ma & mb;
        ALU_OP_OR:   ne.res = ma | mb;
        ALU_OP_NAND: ne.res = ~(ma & mb);
        ALU_OP_NOR:  ne.res = ~(ma | mb);
        ALU_OP_XOR:  ne.res = ma ^ mb;
        ALU_OP_MOV:  ne.res = ma;
        ALU_OP_LI:   ne.res = mb;
        ALU_OP_SHL:  ne.res = ma << sa;
        ALU_OP_SHR:  ne.res = ma >> sa;
        ALU_OP_SAR:  ne.res = ma[W-1] ? ~((~ma) >> sa) : (ma >> sa);
        ALU_OP_CMP, ALU_OP_TEST: begin
          ne.res = (alu_op == ALU_OP_CMP) ? (ma - mb) : (ma & mb);
          m_fl  = {ne.res == '0, ma < mb, ma > mb};
          m_sfl = {ne.res == '0, $signed(ma) < $signed(mb), $signed(ma) > $signed(mb)};
        end
        ALU_OP_MUL: begin
          prod = {32'd0, ma} * {32'd0, mb};
          ne.res = prod[W-1:0];
          ne.due = cyc + W;
          busy_end = cyc + W;
        end
        ALU_OP_DIV, ALU_OP_MOD: begin
          if (mb == '0) ne.res = (alu_op == ALU_OP_DIV) ? '1 : ma;
          else          ne.res = (alu_op == ALU_OP_DIV) ? (ma / mb) : (ma % mb);
          m_dz = (mb == '0);
          ne.due = cyc + W;
          busy_end = cyc + W;
        end
        default: ne.res = '0;
      endcase
      ne.fl = m_fl;
      ne.sfl = m_sfl;
      ne.dz = m_dz;
      ne.lit_use = lit_use;
      ne.lit_res = lit_res;
      ne.lit_fl_use = lit_fl_use;
      ne.lit_fl = lit_fl;
      ne.lit_sfl = lit_sfl;
      q.push_back(ne);
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      automatic logic         ev = (q.size() > 0) && (q[0].due <= cyc);
      automatic logic         eb = (cyc < busy_end);
      automatic logic [W-1:0] er = ev ? q[0].res : sh_res;
      automatic logic         ec = ev ? q[0].cmp : sh_cmp;
      automatic logic [2:0]   ef = ev ? q[0].fl  : sh_fl;
      automatic logic [2:0]   es = ev ? q[0].sfl : sh_sfl;
      automatic logic         ed = ev ? q[0].dz  : sh_dz;
      chk1("out_valid", out_valid, ev);
      chk1("busy", busy, eb);
      chk1("in_ready", in_ready, !eb && (!ev || out_ready));
      chkw("alu_result", alu_result, er);
      chk1("compare", compare, ec);
      chk1("zero", zero, ef[2]);
      chk1("less", less, ef[1]);
      chk1("greater", greater, ef[0]);
      chk1("div_zero", div_zero, ed);
      chk1("s_out_valid", s_out_valid, ev);
      chk1("s_busy", s_busy, eb);
      chk1("s_in_ready", s_in_ready, !eb && (!ev || out_ready));
      chkw("s_alu_result", s_alu_result, er);
      chk1("s_compare", s_compare, ec);
      chk1("s_zero", s_zero, es[2]);
      chk1("s_less", s_less, es[1]);
      chk1("s_greater", s_greater, es[0]);
      chk1("s_div_zero", s_div_zero, ed);
      if (ev && q[0].lit_use) begin
        chkw("lit_result", alu_result, q[0].lit_res);
        q[0].lit_use = 1'b0;
      end
      if (ev && q[0].lit_fl_use) begin
        chkw("lit_flags", W'({div_zero, zero, less, greater}), W'(q[0].lit_fl));
        chkw("lit_sflags", W'({s_zero, s_less, s_greater}), W'(q[0].lit_sfl));
        q[0].lit_fl_use = 1'b0;
      end
      if (ev && out_ready) begin
        sh_res = q[0].res; sh_cmp = q[0].cmp; sh_fl = q[0].fl;
        sh_sfl = q[0].sfl; sh_dz = q[0].dz;
        void'(q.pop_front());
      end
    end
  end

  task automatic issue(input logic [ALU_OP_BITS-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic lu, input logic [W-1:0] lr,
                       input logic fu, input logic [3:0] lf, input logic [2:0] lsf);
    int n = 0;
    lit_use = lu; lit_res = lr; lit_fl_use = fu; lit_fl = lf; lit_sfl = lsf;
    alu_op = op; data1 = a; data2 = b; in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL accept_timeout op=%0d: got in_ready=0 want 1 within 200 cycles", op);
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    alu_op = ALU_OP_BITS'($urandom_range(0, 31));
    data1 = $urandom;
    data2 = $urandom;
  endtask

  task automatic opr(input logic [ALU_OP_BITS-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] r);
    issue(op, a, b, 1'b1, r, 1'b0, 4'd0, 3'd0);
  endtask

  task automatic opf(input logic [ALU_OP_BITS-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] r, input logic [3:0] f, input logic [2:0] sf);
    issue(op, a, b, 1'b1, r, 1'b1, f, sf);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || busy_end > cyc) && n < 300) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d results pending want 0", q.size());
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    // flags literal order: {div_zero, zero, less, greater}; signed: {zero, less, greater}
    opf(ALU_OP_ADD, 32'hFFFFFFFF, 32'h1, 32'h0, 4'b0000, 3'b000);
    opr(ALU_OP_SAR, 32'h80000000, 32'd4, 32'hF8000000);
    opr(ALU_OP_SHR, 32'h80000000, 32'd4, 32'h08000000);
    opr(ALU_OP_SAR, 32'h80000000, 32'd36, 32'hF8000000);
    opr(ALU_OP_SHL, 32'h1, 32'd36, 32'h10);
    opf(ALU_OP_CMP, 32'd3, 32'd7, 32'hFFFFFFFC, 4'b0010, 3'b010);
    opf(ALU_OP_ADD, 32'd1, 32'd1, 32'd2, 4'b0010, 3'b010);
    opf(ALU_OP_CMP, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFE, 4'b0001, 3'b010);
    opf(ALU_OP_TEST, 32'hF0, 32'h0F, 32'h0, 4'b0101, 3'b101);
    opf(ALU_OP_SUB, 32'd5, 32'd7, 32'hFFFFFFFE, 4'b0101, 3'b101);
    opr(ALU_OP_NOT, 32'h0F0F0F0F, 32'h0, 32'hF0F0F0F0);
    opr(ALU_OP_AND, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00);
    opr(ALU_OP_OR, 32'hFF00FF00, 32'h0FF00FF0, 32'hFFF0FFF0);
    opr(ALU_OP_NAND, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0FFF0FF);
    opr(ALU_OP_NOR, 32'hFF00FF00, 32'h0FF00FF0, 32'h000F000F);
    opr(ALU_OP_XOR, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0);
    opr(ALU_OP_MOV, 32'h12345678, 32'h9, 32'h12345678);
    opr(ALU_OP_LI, 32'h9, 32'hCAFEBABE, 32'hCAFEBABE);
    opf(5'd31, 32'd1, 32'd2, 32'h0, 4'b0101, 3'b101);
    opf(ALU_OP_CMP, 32'd9, 32'd9, 32'h0, 4'b0100, 3'b100);
    opf(ALU_OP_MUL, 32'd12345, 32'd678, 32'd8369910, 4'b0100, 3'b100);
    opr(ALU_OP_DIV, 32'd100, 32'd7, 32'd14);
    opr(ALU_OP_MOD, 32'd100, 32'd7, 32'd2);
    opf(ALU_OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 4'b1100, 3'b100);
    opf(ALU_OP_MOD, 32'd5, 32'd0, 32'd5, 4'b1100, 3'b100);
    opf(ALU_OP_DIV, 32'd100, 32'd7, 32'd14, 4'b0100, 3'b100);
    opr(ALU_OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1);
    opr(ALU_OP_DIV, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF);
    opr(ALU_OP_MOD, 32'd7, 32'd100, 32'd7);
    wait_idle();

    // Backpressure on a single-cycle result, then on a multi-cycle result.
    out_ready = 1'b0;
    opr(ALU_OP_ADD, 32'd2, 32'd3, 32'd5);
    fork
      opr(ALU_OP_XOR, 32'd6, 32'd3, 32'd5);
      begin repeat (6) @(posedge clk); #2 out_ready = 1'b1; end
    join
    wait_idle();
    out_ready = 1'b0;
    opr(ALU_OP_MUL, 32'd3, 32'd4, 32'd12);
    fork
      opr(ALU_OP_ADD, 32'd7, 32'd8, 32'd15);
      begin repeat (40) @(posedge clk); #2 out_ready = 1'b1; end
    join
    wait_idle();

    // Reset partway through a divide: no result may appear for it.
    issue(ALU_OP_DIV, 32'd1000, 32'd3, 1'b0, 32'd0, 1'b0, 4'd0, 3'd0);
    repeat (9) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    opf(ALU_OP_ADD, 32'd4, 32'd4, 32'd8, 4'b0000, 3'b000);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
